// File: rtl/syndrome_frame_ctrl.sv
// Frame controller for the PE grid: assembles serial syndrome bits, loads and times the offer window, returns captured match values.
// Optional build macro ZERO_SKIP_EN: all-zero frames bypass the offer sequence and report result_empty.
module syndrome_frame_ctrl #(
    parameter int ROWS              = 2,
    parameter int COLS              = 3,
    parameter int MATCH_VALUE_WIDTH = 8,
    parameter int SETTLE_CYCLES     = 4,
    parameter int DRAIN_CYCLES      = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                s_bit,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [15:0]                         offer_cycles,
    output logic [ROWS*COLS-1:0]                measurement_value_out,
    output logic [ROWS*COLS-1:0]                measurement_valid_out,
    output logic                                start_offer,
    output logic                                stop_offer,
    input  logic [ROWS*COLS*MATCH_VALUE_WIDTH-1:0] match_value_in,
    output logic [ROWS*COLS*MATCH_VALUE_WIDTH-1:0] result_data,
    output logic                                result_empty,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic                                busy
);
    localparam int NPE   = ROWS * COLS;
    localparam int CNT_W = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int RES_W = NPE * MATCH_VALUE_WIDTH;

    typedef enum logic [3:0] {
        ST_LOAD    = 4'd0,
        ST_ISSUE   = 4'd1,
        ST_SETTLE  = 4'd2,
        ST_START   = 4'd3,
        ST_RUN     = 4'd4,
        ST_STOP    = 4'd5,
        ST_DRAIN   = 4'd6,
        ST_CAPTURE = 4'd7,
        ST_OUTPUT  = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [NPE-1:0]     r_frame;
    logic [NPE-1:0]     w_frame_next;
    logic [7:0]         r_wait_cnt;
    logic [15:0]        r_offer_cnt;
    logic               w_accept;
    logic               w_last_bit;
    logic               w_frame_zero;

    logic [NPE-1:0]     r_meas_value;
    logic [NPE-1:0]     r_meas_valid;
    logic               r_start_offer;
    logic               r_stop_offer;
    logic [RES_W-1:0]   r_result_data;
    logic               r_result_valid;
    logic               r_s_ready;
    logic               r_busy;
    logic [NPE-1:0]     w_meas_valid_next;
    logic               w_start_next;
    logic               w_stop_next;
    logic               w_result_valid_next;
    logic               w_s_ready_next;
    logic               w_busy_next;

    assign w_accept   = s_valid & r_s_ready;
    assign w_last_bit = w_accept & (r_bit_cnt == CNT_W'(NPE - 1));

`ifdef ZERO_SKIP_EN
    logic r_result_empty;
    assign w_frame_zero = (r_frame == {NPE{1'b0}});
    assign result_empty = r_result_empty;

    // Empty flag is decided once per frame in ISSUE and held through OUTPUT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result_empty <= 1'b0;
        end else if (r_state == ST_ISSUE) begin
            r_result_empty <= w_frame_zero;
        end else begin
            r_result_empty <= r_result_empty;
        end
    end
`else
    assign w_frame_zero = 1'b0;
    assign result_empty = 1'b0;
`endif

    // Frame image including the bit accepted this cycle, so ISSUE sees the complete frame
    always_comb begin
        w_frame_next = r_frame;
        if (w_accept) begin
            w_frame_next[r_bit_cnt] = s_bit;
        end else begin
            w_frame_next = r_frame;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:    w_state_next = w_last_bit ? ST_ISSUE : ST_LOAD;
            ST_ISSUE:   w_state_next = w_frame_zero ? ST_OUTPUT : ST_SETTLE;
            ST_SETTLE:  w_state_next = (r_wait_cnt == 8'd1) ? ST_START : ST_SETTLE;
            ST_START:   w_state_next = ST_RUN;
            ST_RUN:     w_state_next = (r_offer_cnt == 16'd1) ? ST_STOP : ST_RUN;
            ST_STOP:    w_state_next = ST_DRAIN;
            ST_DRAIN:   w_state_next = (r_wait_cnt == 8'd1) ? ST_CAPTURE : ST_DRAIN;
            ST_CAPTURE: w_state_next = ST_OUTPUT;
            ST_OUTPUT:  w_state_next = result_ready ? ST_LOAD : ST_OUTPUT;
            default:    w_state_next = ST_LOAD;
        endcase
    end

    // Output decode from the upcoming state so every port comes straight from a flop
    always_comb begin
        w_meas_valid_next   = (w_state_next == ST_ISSUE) ? {NPE{1'b1}} : {NPE{1'b0}};
        w_start_next        = (w_state_next == ST_START);
        w_stop_next         = (w_state_next == ST_STOP);
        w_result_valid_next = (w_state_next == ST_OUTPUT);
        w_s_ready_next      = (w_state_next == ST_LOAD);
        w_busy_next         = (w_state_next != ST_LOAD);
    end

    // Control output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meas_valid   <= {NPE{1'b0}};
            r_start_offer  <= 1'b0;
            r_stop_offer   <= 1'b0;
            r_result_valid <= 1'b0;
            r_s_ready      <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            r_meas_valid   <= w_meas_valid_next;
            r_start_offer  <= w_start_next;
            r_stop_offer   <= w_stop_next;
            r_result_valid <= w_result_valid_next;
            r_s_ready      <= w_s_ready_next;
            r_busy         <= w_busy_next;
        end
    end

    // Bit assembly and the settle/drain and offer-window counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_frame     <= {NPE{1'b0}};
            r_wait_cnt  <= 8'd0;
            r_offer_cnt <= 16'd0;
        end else begin
            r_frame <= w_frame_next;
            if (w_last_bit) begin
                r_bit_cnt <= {CNT_W{1'b0}};
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
            case (r_state)
                ST_ISSUE:  r_wait_cnt <= 8'(SETTLE_CYCLES);
                ST_STOP:   r_wait_cnt <= 8'(DRAIN_CYCLES);
                ST_SETTLE, ST_DRAIN: r_wait_cnt <= r_wait_cnt - 8'd1;
                default:   r_wait_cnt <= r_wait_cnt;
            endcase
            // A zero-length window still runs for one cycle
            if (r_state == ST_START) begin
                r_offer_cnt <= (offer_cycles == 16'd0) ? 16'd1 : offer_cycles;
            end else if (r_state == ST_RUN) begin
                r_offer_cnt <= r_offer_cnt - 16'd1;
            end else begin
                r_offer_cnt <= r_offer_cnt;
            end
        end
    end

    // Frame and result data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meas_value  <= {NPE{1'b0}};
            r_result_data <= {RES_W{1'b0}};
        end else begin
            if (w_last_bit) begin
                r_meas_value <= w_frame_next;
            end else begin
                r_meas_value <= r_meas_value;
            end
            if (r_state == ST_CAPTURE) begin
                r_result_data <= match_value_in;
            end else if ((r_state == ST_ISSUE) && w_frame_zero) begin
                r_result_data <= {RES_W{1'b0}};
            end else begin
                r_result_data <= r_result_data;
            end
        end
    end

    assign s_ready               = r_s_ready;
    assign busy                  = r_busy;
    assign measurement_value_out = r_meas_value;
    assign measurement_valid_out = r_meas_valid;
    assign start_offer           = r_start_offer;
    assign stop_offer            = r_stop_offer;
    assign result_data           = r_result_data;
    assign result_valid          = r_result_valid;
endmodule

// File: tb/tb_syndrome_frame_ctrl.sv
// Self-checking bench for syndrome_frame_ctrl: randomized frames checked against a cycle-count model.
module tb_syndrome_frame_ctrl;
    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int MVW  = 8;
    localparam int NPE  = ROWS * COLS;
    localparam int RW   = NPE * MVW;
    localparam int S    = 4;
    localparam int D    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            s_bit;
    logic            s_valid;
    logic            s_ready;
    logic [15:0]     offer_cycles;
    logic [NPE-1:0]  measurement_value_out;
    logic [NPE-1:0]  measurement_valid_out;
    logic            start_offer;
    logic            stop_offer;
    logic [RW-1:0]   match_value_in;
    logic [RW-1:0]   result_data;
    logic            result_empty;
    logic            result_valid;
    logic            result_ready;
    logic            busy;

    int checks = 0;
    int errors = 0;

    syndrome_frame_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .MATCH_VALUE_WIDTH(MVW),
        .SETTLE_CYCLES(S), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .s_bit(s_bit), .s_valid(s_valid), .s_ready(s_ready),
        .offer_cycles(offer_cycles), .measurement_value_out(measurement_value_out),
        .measurement_valid_out(measurement_valid_out), .start_offer(start_offer),
        .stop_offer(stop_offer), .match_value_in(match_value_in), .result_data(result_data),
        .result_empty(result_empty), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    // Reference model: cycle offsets counted from the ISSUE cycle (offset 0)
    function automatic bit skips(input logic [NPE-1:0] f);
        return ZS && (f == '0);
    endfunction
    function automatic int eff_n(input int offer);
        return (offer == 0) ? 1 : offer;
    endfunction
    function automatic int exp_latency(input logic [NPE-1:0] f, input int offer);
        if (skips(f)) return 1;
        return 1 + S + 1 + eff_n(offer) + 1 + D + 1;
    endfunction

    task automatic apply_reset(input int n);
        reset = 1'b1; s_valid = 1'b0; result_ready = 1'b0;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [NPE-1:0] bits, input int gap_mode);
        int g;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready: s_ready=%b expected 1", s_ready);
        end
        for (int k = 0; k < NPE; k++) begin
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                s_valid = 1'b0; s_bit = 1'($urandom); step();
            end
            s_valid = 1'b1; s_bit = bits[k]; step();
        end
        s_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [NPE-1:0] bits, input int offer, input int gap_mode,
                             input int hold, input bit drive_busy, input bit ready_early,
                             input bit seq_match);
        logic [RW-1:0] m, exp_data;
        int lat, rel, obs_rel, start_rel, stop_rel, nstart, nstop, nmv;
        bit seen, busy_bad, overlap, hold_bad;
        for (int k = 0; k < NPE; k++)
            m[k*MVW +: MVW] = seq_match ? MVW'(k + 1) : MVW'($urandom);
        match_value_in = m;
        offer_cycles   = 16'(offer);
        result_ready   = ready_early;
        exp_data = skips(bits) ? '0 : m;
        lat = exp_latency(bits, offer);
        send_frame(bits, gap_mode);

        checks++;
        if (measurement_valid_out !== {NPE{1'b1}} || measurement_value_out !== bits) begin
            errors++;
            $display("FAIL issue: valid=%b value=%b expected valid=%b value=%b",
                     measurement_valid_out, measurement_value_out, {NPE{1'b1}}, bits);
        end

        rel = 0; seen = 0; obs_rel = -1; start_rel = -1; stop_rel = -1;
        nstart = 0; nstop = 0; nmv = 0; busy_bad = 0; overlap = 0;
        while (!seen && rel < lat + 40) begin
            if (drive_busy) begin s_valid = 1'b1; s_bit = 1'($urandom); end
            step();
            rel++;
            if (start_offer === 1'b1) begin nstart++; if (start_rel < 0) start_rel = rel; end
            if (stop_offer === 1'b1) begin nstop++; if (stop_rel < 0) stop_rel = rel; end
            if (start_offer === 1'b1 && stop_offer === 1'b1) overlap = 1;
            if (measurement_valid_out !== '0) nmv++;
            if (s_ready !== 1'b0 || busy !== 1'b1) busy_bad = 1;
            if (result_valid === 1'b1) begin seen = 1; obs_rel = rel; end
        end
        s_valid = 1'b0;

        checks++;
        if (!seen || obs_rel != lat) begin
            errors++; $display("FAIL latency: result_valid at %0d expected %0d", obs_rel, lat);
        end
        checks++;
        if (start_rel != (skips(bits) ? -1 : 1 + S) || nstart != (skips(bits) ? 0 : 1)) begin
            errors++; $display("FAIL start_offer: at %0d count %0d expected at %0d count %0d",
                start_rel, nstart, skips(bits) ? -1 : 1 + S, skips(bits) ? 0 : 1);
        end
        checks++;
        if (stop_rel != (skips(bits) ? -1 : 2 + S + eff_n(offer)) || nstop != (skips(bits) ? 0 : 1)) begin
            errors++; $display("FAIL stop_offer: at %0d count %0d expected at %0d count %0d",
                stop_rel, nstop, skips(bits) ? -1 : 2 + S + eff_n(offer), skips(bits) ? 0 : 1);
        end
        checks++;
        if (nmv != 0 || busy_bad || overlap) begin
            errors++; $display("FAIL busy_phase: extra_loads=%0d busy_bad=%0d overlap=%0d expected 0 0 0",
                nmv, busy_bad, overlap);
        end
        checks++;
        if (result_data !== exp_data || result_empty !== skips(bits)) begin
            errors++; $display("FAIL result: data=%h empty=%b expected data=%h empty=%b",
                result_data, result_empty, exp_data, skips(bits));
        end
        if (!seen) begin
            apply_reset(2);
            return;
        end

        hold_bad = 0;
        if (!ready_early) begin
            for (int h = 0; h < hold; h++) begin
                result_ready = 1'b0;
                for (int k = 0; k < NPE; k++) match_value_in[k*MVW +: MVW] = MVW'($urandom);
                step();
                if (result_valid !== 1'b1 || result_data !== exp_data || result_empty !== skips(bits)
                    || s_ready !== 1'b0 || busy !== 1'b1) hold_bad = 1;
            end
            if (hold > 0) begin
                checks++;
                if (hold_bad) begin
                    errors++; $display("FAIL backpressure: valid=%b data=%h expected valid=1 data=%h held",
                        result_valid, result_data, exp_data);
                end
            end
            result_ready = 1'b1;
        end
        step();
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL handshake: valid=%b s_ready=%b busy=%b expected 0 1 0",
                result_valid, s_ready, busy);
        end
    endtask

    task automatic test_reset();
        s_bit = 1'b0; offer_cycles = 16'd0; match_value_in = '0;
        apply_reset(3);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || result_empty !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: s_ready=%b busy=%b valid=%b empty=%b expected 1 0 0 0",
                s_ready, busy, result_valid, result_empty);
        end
        checks++;
        if (measurement_value_out !== '0 || measurement_valid_out !== '0 || start_offer !== 1'b0
            || stop_offer !== 1'b0 || result_data !== '0) begin
            errors++; $display("FAIL reset_data: mv=%b mvl=%b start=%b stop=%b data=%h expected all 0",
                measurement_value_out, measurement_valid_out, start_offer, stop_offer, result_data);
        end
    endtask

    task automatic test_reset_in_run();
        int t;
        offer_cycles = 16'd30;
        send_frame(NPE'($urandom) | NPE'(1), 0);
        t = 0;
        while (start_offer !== 1'b1 && t < 30) begin step(); t++; end
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (start_offer !== 1'b0 || stop_offer !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0
            || result_valid !== 1'b0 || measurement_value_out !== '0) begin
            errors++; $display("FAIL reset_in_run: start=%b stop=%b s_ready=%b busy=%b valid=%b mv=%b expected 0 0 1 0 0 0",
                start_offer, stop_offer, s_ready, busy, result_valid, measurement_value_out);
        end
        run_frame(6'b010110, 2, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_bit = 1'b0; result_ready = 1'b0;
        offer_cycles = 16'd0; match_value_in = '0;
        test_reset();
        // First bit lands in PE 0_0: bits 1,0,0,0,0,1 form 6'b100001
        run_frame(6'b100001, 10, 0, 0, 0, 0, 1);
        run_frame(NPE'($urandom) | NPE'(2), 3, 0, 7, 0, 0, 0);
        run_frame(6'b011010, 5, 1, 2, 1, 0, 0);
        run_frame(6'b110011, 4, 2, 0, 1, 1, 0);
        test_reset_in_run();
        run_frame(6'b000100, 0, 0, 1, 0, 0, 0);
        run_frame(6'b000000, 6, 0, 3, 0, 0, 0);
        run_frame(6'b000000, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++)
            run_frame(NPE'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
